// File: rtl/skin_frame_sequencer.sv
// Frame sequencer around the skin classifier: pixel tagging, mask re-emit, per-frame summary.
// Optional bounding box tracking is enabled by defining SKIN_BBOX_EN.
module skin_frame_sequencer #(
    parameter int unsigned IMG_W = 160,
    parameter int unsigned IMG_H = 120,
    parameter int unsigned XW    = 8,
    parameter int unsigned YW    = 8,
    parameter int unsigned CNT_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             pix_sof,
    input  logic [7:0]       pix_y,
    input  logic [7:0]       pix_cb,
    input  logic [7:0]       pix_cr,
    output logic [7:0]       luma_ch,
    output logic [7:0]       cb_ch,
    output logic [7:0]       cr_ch,
    input  logic             object_image,
    output logic             mask_valid,
    output logic             mask_bit,
    output logic [XW-1:0]    mask_x,
    output logic [YW-1:0]    mask_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic [XW-1:0]    res_xmin,
    output logic [XW-1:0]    res_xmax,
    output logic [YW-1:0]    res_ymin,
    output logic [YW-1:0]    res_ymax,
    output logic             res_empty,
    output logic             res_resync,
    output logic             busy
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSync   = 3'd1;
    localparam logic [2:0] StScan   = 3'd2;
    localparam logic [2:0] StDrain  = 3'd3;
    localparam logic [2:0] StReport = 3'd4;

    localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

    logic [2:0]       state_q, state_d;
    logic [XW-1:0]    x_q, cur_x;
    logic [YW-1:0]    y_q, cur_y;
    logic             t1_v_q, t2_v_q;
    logic [XW-1:0]    t1_x_q, t2_x_q;
    logic [YW-1:0]    t1_y_q, t2_y_q;
    logic [CNT_W-1:0] count_q;
    logic             resync_q;
    logic             accept, sof_hit, resync_hit, pix_take, last_pix;
    logic             clear_acc, skin_hit, report, empty;

    assign pix_ready  = (state_q == StSync) || (state_q == StScan);
    assign accept     = pix_valid && pix_ready;
    assign sof_hit    = accept && pix_sof;
    assign resync_hit = sof_hit && (state_q == StScan);
    // In SYNC only the sof beat enters the pipe; everything before it is discarded.
    assign pix_take   = (state_q == StSync) ? sof_hit : (accept && state_q == StScan);
    assign cur_x      = pix_sof ? '0 : x_q;
    assign cur_y      = pix_sof ? '0 : y_q;
    assign last_pix   = (cur_x == XLast) && (cur_y == YLast);
    assign clear_acc  = ((state_q == StIdle) && start) || resync_hit;
    assign skin_hit   = t2_v_q && object_image;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:         if (start) state_d = StSync;
            StSync, StScan: if (pix_take) state_d = last_pix ? StDrain : StScan;
            StDrain:        if (!t1_v_q && !t2_v_q) state_d = StReport;
            StReport:       if (res_ready) state_d = StIdle;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            t1_v_q   <= 1'b0;
            t2_v_q   <= 1'b0;
            t1_x_q   <= '0;
            t1_y_q   <= '0;
            t2_x_q   <= '0;
            t2_y_q   <= '0;
            luma_ch  <= '0;
            cb_ch    <= '0;
            cr_ch    <= '0;
            count_q  <= '0;
            resync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            t1_v_q  <= pix_take;
            // A resync drops whatever was about to reach stage 2.
            t2_v_q  <= t1_v_q && !resync_hit;
            t2_x_q  <= t1_x_q;
            t2_y_q  <= t1_y_q;
            if (pix_take) begin
                luma_ch <= pix_y;
                cb_ch   <= pix_cb;
                cr_ch   <= pix_cr;
                t1_x_q  <= cur_x;
                t1_y_q  <= cur_y;
                if (cur_x == XLast) begin
                    x_q <= '0;
                    y_q <= (cur_y == YLast) ? '0 : cur_y + 1'b1;
                end else begin
                    x_q <= cur_x + 1'b1;
                    y_q <= cur_y;
                end
            end
            if (clear_acc) begin
                count_q <= '0;
            end else if (skin_hit) begin
                count_q <= count_q + 1'b1;
            end
            if ((state_q == StIdle) && start) begin
                resync_q <= 1'b0;
            end else if (resync_hit) begin
                resync_q <= 1'b1;
            end
        end
    end

    assign report     = (state_q == StReport);
    assign empty      = (count_q == '0);
    assign busy       = (state_q != StIdle);
    assign mask_valid = t2_v_q;
    assign mask_bit   = skin_hit;
    assign mask_x     = t2_x_q;
    assign mask_y     = t2_y_q;
    assign res_valid  = report;
    assign res_count  = report ? count_q : '0;
    assign res_empty  = report && empty;
    assign res_resync = report && resync_q;

`ifdef SKIN_BBOX_EN
    logic [XW-1:0] xmin_q, xmax_q;
    logic [YW-1:0] ymin_q, ymax_q;

    always_ff @(posedge clk) begin
        if (rst || clear_acc) begin
            xmin_q <= '1;
            xmax_q <= '0;
            ymin_q <= '1;
            ymax_q <= '0;
        end else if (skin_hit) begin
            if (t2_x_q < xmin_q) xmin_q <= t2_x_q;
            if (t2_x_q > xmax_q) xmax_q <= t2_x_q;
            if (t2_y_q < ymin_q) ymin_q <= t2_y_q;
            if (t2_y_q > ymax_q) ymax_q <= t2_y_q;
        end
    end

    assign res_xmin = (report && !empty) ? xmin_q : '0;
    assign res_xmax = (report && !empty) ? xmax_q : '0;
    assign res_ymin = (report && !empty) ? ymin_q : '0;
    assign res_ymax = (report && !empty) ? ymax_q : '0;
`else
    assign res_xmin = '0;
    assign res_xmax = '0;
    assign res_ymin = '0;
    assign res_ymax = '0;
`endif

endmodule
